// File: rtl/mode_sw_pkg.sv
// Shared constants for the mode-switch controller: register addresses and edge-type encodings.
package mode_sw_pkg;

    localparam logic [1:0] ADDR_DATA = 2'd0;
    localparam logic [1:0] ADDR_RAW  = 2'd1;
    localparam logic [1:0] ADDR_MASK = 2'd2;
    localparam logic [1:0] ADDR_EDGE = 2'd3;

    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_BOTH = 2;

endpackage

// File: rtl/sw_debounce.sv
// One switch bit: two-flop synchroniser followed by a stable-count debouncer.
module sw_debounce #(
    parameter int DEB_CYCLES = 50000,
    parameter int CNT_W      = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic i_raw,
    output logic o_sync,
    output logic o_level
);

    logic             r_meta;
    logic             r_sync;
    logic             r_level;
    logic [CNT_W-1:0] r_cnt;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_meta  <= 1'b0;
            r_sync  <= 1'b0;
            r_level <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_meta <= i_raw;
            r_sync <= r_meta;
            if (r_sync == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_W'(DEB_CYCLES - 1)) begin
                r_level <= r_sync;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign o_sync  = r_sync;
    assign o_level = r_level;

endmodule

// File: rtl/mode_sw_ctrl.sv
// Avalon-MM mode-switch front end: debounce, edge capture, read mux and optional irq.
// Optional MASK register and irq output are enabled by defining MODE_SW_CTRL_IRQ_EN.
module mode_sw_ctrl
    import mode_sw_pkg::*;
#(
    parameter int N_SW       = 4,
    parameter int DEB_CYCLES = 50000,
    parameter int CNT_W      = 16,
    parameter int EDGE_TYPE  = 0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [1:0]      address,
    input  logic            chipselect,
    input  logic            write,
    input  logic [N_SW-1:0] writedata,
    output logic [N_SW-1:0] readdata,
    input  logic [N_SW-1:0] in_port,
    output logic            irq
);

    logic [N_SW-1:0] w_sync;
    logic [N_SW-1:0] w_level;
    logic [N_SW-1:0] w_rise;
    logic [N_SW-1:0] w_fall;
    logic [N_SW-1:0] w_edge;
    logic [N_SW-1:0] w_clr;
    logic [N_SW-1:0] w_mask_rd;
    logic [N_SW-1:0] w_rd_mux;
    logic            w_wr;
    logic [N_SW-1:0] r_level_d;
    logic [N_SW-1:0] r_edge_cap;
    logic [N_SW-1:0] r_readdata;

    for (genvar i = 0; i < N_SW; i++) begin : g_deb
        sw_debounce #(
            .DEB_CYCLES (DEB_CYCLES),
            .CNT_W      (CNT_W)
        ) u_deb (
            .clk     (clk),
            .reset   (reset),
            .i_raw   (in_port[i]),
            .o_sync  (w_sync[i]),
            .o_level (w_level[i])
        );
    end

    assign w_rise = w_level & ~r_level_d;
    assign w_fall = ~w_level & r_level_d;
    assign w_wr   = chipselect & write;
    assign w_clr  = (w_wr && address == ADDR_EDGE) ? writedata : '0;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_edge = w_rise;
        case (EDGE_TYPE)
            EDGE_RISE: w_edge = w_rise;
            EDGE_FALL: w_edge = w_fall;
            EDGE_BOTH: w_edge = w_rise | w_fall;
            default:   w_edge = w_rise;
        endcase
    end

    // Set has priority over write-1-clear so an edge in the clearing cycle is never lost.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_level_d  <= '0;
            r_edge_cap <= '0;
        end else begin
            r_level_d  <= w_level;
            r_edge_cap <= (r_edge_cap & ~w_clr) | w_edge;
        end
    end

`ifdef MODE_SW_CTRL_IRQ_EN
    logic [N_SW-1:0] r_irq_mask;
    logic            r_irq;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_irq_mask <= '0;
            r_irq      <= 1'b0;
        end else begin
            if (w_wr && address == ADDR_MASK) begin
                r_irq_mask <= writedata;
            end
            r_irq <= |(r_edge_cap & r_irq_mask);
        end
    end

    assign w_mask_rd = r_irq_mask;
    assign irq       = r_irq;
`else
    assign w_mask_rd = '0;
    assign irq       = 1'b0;
`endif

    always_comb begin
        w_rd_mux = '0;
        case (address)
            ADDR_DATA: w_rd_mux = w_level;
            ADDR_RAW:  w_rd_mux = w_sync;
            ADDR_MASK: w_rd_mux = w_mask_rd;
            ADDR_EDGE: w_rd_mux = r_edge_cap;
            default:   w_rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_readdata <= '0;
        end else begin
            r_readdata <= w_rd_mux;
        end
    end

    assign readdata = r_readdata;

endmodule

// File: tb/tb_mode_sw_ctrl.sv
// Directed bench for mode_sw_ctrl with N_SW=4, DEB_CYCLES=4, rising-edge capture.
module tb_mode_sw_ctrl;

`ifdef MODE_SW_CTRL_IRQ_EN
    localparam bit IRQ_EN = 1'b1;
`else
    localparam bit IRQ_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] address = 2'd0;
    logic       chipselect = 1'b0;
    logic       write = 1'b0;
    logic [3:0] writedata = 4'h0;
    logic [3:0] readdata;
    logic [3:0] in_port = 4'h0;
    logic       irq;

    int n_tests = 0;
    int n_fail  = 0;

    mode_sw_ctrl #(
        .N_SW       (4),
        .DEB_CYCLES (4),
        .CNT_W      (3),
        .EDGE_TYPE  (0)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .chipselect (chipselect),
        .write      (write),
        .writedata  (writedata),
        .readdata   (readdata),
        .in_port    (in_port),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] in_v;
        logic [1:0] addr;
        logic       cs;
        logic       wr;
        logic [3:0] wd;
        logic [3:0] exp_rd;
        logic       exp_irq;
    } vec_t;

    vec_t vecs [21];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Drive one cycle of bus/switch inputs, then land 1 time unit after the rising edge.
    task automatic step(input logic [3:0] in_v, input logic [1:0] addr, input logic cs,
                        input logic wr, input logic [3:0] wd);
        in_port    = in_v;
        address    = addr;
        chipselect = cs;
        write      = wr;
        writedata  = wd;
        @(posedge clk);
        #1;
    endtask

    // Expected values are written for the IRQ-enabled build; without it MASK reads 0 and irq is 0.
    task automatic step_chk(input string name, input logic [3:0] in_v, input logic [1:0] addr,
                            input logic cs, input logic wr, input logic [3:0] wd,
                            input logic [3:0] exp_rd, input logic exp_irq);
        logic [3:0] e_rd;
        logic       e_irq;
        step(in_v, addr, cs, wr, wd);
        e_rd  = (!IRQ_EN && addr == 2'd2) ? 4'h0 : exp_rd;
        e_irq = IRQ_EN ? exp_irq : 1'b0;
        check({name, "_rd"}, 32'(readdata), 32'(e_rd));
        check({name, "_irq"}, 32'(irq), 32'(e_irq));
    endtask

    initial begin
        //            in    adr cs wr wd    rd    irq
        vecs[0]  = '{4'h0, 2'd0, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0};
        vecs[1]  = '{4'h0, 2'd1, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0};
        vecs[2]  = '{4'h0, 2'd2, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0};
        vecs[3]  = '{4'h0, 2'd3, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0};
        vecs[4]  = '{4'h0, 2'd2, 1'b1, 1'b1, 4'h1, 4'h0, 1'b0};
        vecs[5]  = '{4'h1, 2'd2, 1'b0, 1'b0, 4'h0, 4'h1, 1'b0};
        vecs[6]  = '{4'h1, 2'd1, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0};
        vecs[7]  = '{4'h1, 2'd1, 1'b0, 1'b0, 4'h0, 4'h1, 1'b0};
        vecs[8]  = '{4'h1, 2'd0, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0};
        vecs[9]  = '{4'h1, 2'd0, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0};
        vecs[10] = '{4'h1, 2'd0, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0};
        vecs[11] = '{4'h1, 2'd0, 1'b0, 1'b0, 4'h0, 4'h1, 1'b0};
        vecs[12] = '{4'h1, 2'd3, 1'b0, 1'b0, 4'h0, 4'h1, 1'b1};
        vecs[13] = '{4'h1, 2'd3, 1'b1, 1'b1, 4'h1, 4'h1, 1'b1};
        vecs[14] = '{4'h1, 2'd3, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0};
        vecs[15] = '{4'h1, 2'd0, 1'b0, 1'b0, 4'h0, 4'h1, 1'b0};
        vecs[16] = '{4'h1, 2'd0, 1'b1, 1'b1, 4'hF, 4'h1, 1'b0};
        vecs[17] = '{4'h1, 2'd1, 1'b1, 1'b1, 4'hF, 4'h1, 1'b0};
        vecs[18] = '{4'h1, 2'd0, 1'b0, 1'b0, 4'h0, 4'h1, 1'b0};
        vecs[19] = '{4'h1, 2'd2, 1'b0, 1'b1, 4'hF, 4'h1, 1'b0};
        vecs[20] = '{4'h1, 2'd2, 1'b0, 1'b0, 4'h0, 4'h1, 1'b0};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_rd", 32'(readdata), 32'h0);
        check("rst_irq", 32'(irq), 32'h0);
        reset = 1'b0;

        // Register reads, bit0 rising edge, mask/irq, W1C, ignored writes
        for (int i = 0; i < 21; i++) begin
            step_chk($sformatf("vec%0d", i), vecs[i].in_v, vecs[i].addr, vecs[i].cs,
                     vecs[i].wr, vecs[i].wd, vecs[i].exp_rd, vecs[i].exp_irq);
        end

        // Three-cycle glitch on bit1 must not reach the debounced level
        for (int i = 0; i < 3; i++) begin
            step_chk($sformatf("glitch_hi%0d", i), 4'h3, 2'd0, 1'b0, 1'b0, 4'h0, 4'h1, 1'b0);
        end
        for (int i = 0; i < 8; i++) begin
            step_chk($sformatf("glitch_lo%0d", i), 4'h1, 2'd0, 1'b0, 1'b0, 4'h0, 4'h1, 1'b0);
        end
        step_chk("glitch_edge", 4'h1, 2'd3, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0);

        // Bit2 rises; write-1-clear lands in the same cycle edge_cap sets
        for (int i = 0; i < 6; i++) begin
            step_chk($sformatf("b2_wait%0d", i), 4'h5, 2'd3, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0);
        end
        step_chk("b2_clr_same", 4'h5, 2'd3, 1'b1, 1'b1, 4'h4, 4'h0, 1'b0);
        step_chk("b2_set_wins", 4'h5, 2'd3, 1'b0, 1'b0, 4'h0, 4'h4, 1'b0);
        step_chk("b2_clr", 4'h5, 2'd3, 1'b1, 1'b1, 4'h4, 4'h4, 1'b0);
        step_chk("b2_cleared", 4'h5, 2'd3, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0);

        // Reset asserted while bits 1 and 3 are mid-count
        for (int i = 0; i < 3; i++) begin
            step_chk($sformatf("pre_rst%0d", i), 4'hF, 2'd0, 1'b0, 1'b0, 4'h0, 4'h5, 1'b0);
        end
        reset = 1'b1;
        #1;
        check("midrst_rd", 32'(readdata), 32'h0);
        check("midrst_irq", 32'(irq), 32'h0);
        @(posedge clk);
        @(posedge clk);
        #1;
        check("midrst_hold_rd", 32'(readdata), 32'h0);
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step_chk($sformatf("post_rst%0d", i), 4'hF, 2'd0, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0);
        end
        step_chk("post_rst_edge0", 4'hF, 2'd3, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0);
        step_chk("post_rst_data", 4'hF, 2'd0, 1'b0, 1'b0, 4'h0, 4'hF, 1'b0);
        step_chk("post_rst_edge", 4'hF, 2'd3, 1'b0, 1'b0, 4'h0, 4'hF, 1'b0);

        // Full mask: irq follows captured edges, or stays 0 without the MASK register
        step_chk("mask_wr", 4'hF, 2'd2, 1'b1, 1'b1, 4'hF, 4'h0, 1'b0);
        step_chk("mask_rd", 4'hF, 2'd2, 1'b0, 1'b0, 4'h0, 4'hF, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
